// File: rtl/gon_pkg.sv
// ============================================================================
// Module : gon_pkg
// Brief  : Shared constants and the tagged psum entry type for the GON collector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gon_pkg;

    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_ROW_TAG_WIDTH  = 4;
    localparam int DEF_COL_TAG_WIDTH  = 4;
    localparam int DEF_NUM_OF_ROWS    = 12;
    localparam int DEF_NUM_OF_COLS    = 14;
    localparam int DEF_GON_FIFO_DEPTH = 64;

    localparam int N_PE     = DEF_NUM_OF_ROWS * DEF_NUM_OF_COLS;
    localparam int PE_IDX_W = $clog2(N_PE);

    // Field order {col,row} matches the GIN tag FIFO.
    typedef struct packed {
        logic [DEF_COL_TAG_WIDTH-1:0] col_tag;
        logic [DEF_ROW_TAG_WIDTH-1:0] row_tag;
        logic [DEF_DATA_WIDTH-1:0]    data;
    } gon_entry_t;

endpackage

`default_nettype wire

// File: rtl/gon_rr_arbiter.sv
// ============================================================================
// Module : gon_rr_arbiter
// Brief  : Round-robin arbiter; the requester closest at/after ptr (mod N) wins.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gon_rr_arbiter
    import gon_pkg::*;
#(
    parameter int N     = N_PE,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W:0] w_cand;
    logic           w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            // ptr is always < N, so one conditional subtract implements the modulo.
            w_cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(N)) begin
                w_cand = w_cand - (IDX_W+1)'(N);
            end
            if (en && !w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found                  = 1'b1;
                gnt[w_cand[IDX_W-1:0]]   = 1'b1;
                gnt_idx                  = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gon_collector.sv
// ============================================================================
// Module : gon_collector
// Brief  : GON return path: round-robin gather of PE psums into a tagged FWFT FIFO.
//          Optional stall counter enabled by defining GON_PERF_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gon_collector
    import gon_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ROW_TAG_WIDTH  = DEF_ROW_TAG_WIDTH,
    parameter int COL_TAG_WIDTH  = DEF_COL_TAG_WIDTH,
    parameter int NUM_OF_ROWS    = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS    = DEF_NUM_OF_COLS,
    parameter int GON_FIFO_DEPTH = DEF_GON_FIFO_DEPTH
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][DATA_WIDTH-1:0] data_in,
    input  logic [NUM_OF_COLS-1:0][NUM_OF_ROWS-1:0]             enable_in,
    output logic [NUM_OF_COLS-1:0][NUM_OF_ROWS-1:0]             ready_out,
    output logic [DATA_WIDTH-1:0]                               out_data,
    output logic [ROW_TAG_WIDTH-1:0]                            out_row,
    output logic [COL_TAG_WIDTH-1:0]                            out_col,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic                                                full,
    output logic [31:0]                                         stall_cnt
);

    localparam int c_n_pe    = NUM_OF_ROWS * NUM_OF_COLS;
    localparam int c_idx_w   = (c_n_pe > 1) ? $clog2(c_n_pe) : 1;
    localparam int c_ptr_w   = $clog2(GON_FIFO_DEPTH);
    localparam int c_entry_w = COL_TAG_WIDTH + ROW_TAG_WIDTH + DATA_WIDTH;

    logic [c_n_pe-1:0]        w_req;
    logic [c_n_pe-1:0]        w_gnt;
    logic [c_idx_w-1:0]       w_gnt_idx;
    logic [DATA_WIDTH-1:0]    w_pe_data [c_n_pe];
    logic [ROW_TAG_WIDTH-1:0] w_pe_row  [c_n_pe];
    logic [COL_TAG_WIDTH-1:0] w_pe_col  [c_n_pe];

    logic [c_entry_w-1:0]     r_mem [GON_FIFO_DEPTH];
    logic [c_ptr_w-1:0]       r_wr_ptr;
    logic [c_ptr_w-1:0]       r_rd_ptr;
    logic [c_ptr_w:0]         r_count;
    logic [c_idx_w-1:0]       r_rr_ptr;

    logic                     w_full;
    logic                     w_valid;
    logic                     w_push;
    logic                     w_pop;
    logic [c_entry_w-1:0]     w_wr_entry;
    logic [c_entry_w-1:0]     w_head;

    // Flatten the 2-D PE array onto idx = r*NUM_OF_COLS + c.
    for (genvar r = 0; r < NUM_OF_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_OF_COLS; c++) begin : g_col
            localparam int c_idx = r * NUM_OF_COLS + c;
            assign w_req[c_idx]     = enable_in[c][r];
            assign ready_out[c][r]  = w_gnt[c_idx];
            assign w_pe_data[c_idx] = data_in[r][c];
            assign w_pe_row[c_idx]  = ROW_TAG_WIDTH'(r);
            assign w_pe_col[c_idx]  = COL_TAG_WIDTH'(c);
        end
    end

    assign w_full  = (r_count == (c_ptr_w+1)'(GON_FIFO_DEPTH));
    assign w_valid = (r_count != '0);

    // No grant during reset: a PE must never see a handshake whose word is discarded.
    gon_rr_arbiter #(
        .N     (c_n_pe),
        .IDX_W (c_idx_w)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .en      (~w_full & ~reset),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_push     = |w_gnt;
    assign w_pop      = w_valid & out_ready;
    assign w_wr_entry = {w_pe_col[w_gnt_idx], w_pe_row[w_gnt_idx], w_pe_data[w_gnt_idx]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                r_rr_ptr <= (w_gnt_idx == c_idx_w'(c_n_pe - 1)) ? '0 : w_gnt_idx + c_idx_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Storage is not reset, so the head is masked while empty.
    assign w_head    = r_mem[r_rd_ptr];
    assign out_data  = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign out_row   = w_valid ? w_head[DATA_WIDTH +: ROW_TAG_WIDTH] : '0;
    assign out_col   = w_valid ? w_head[DATA_WIDTH+ROW_TAG_WIDTH +: COL_TAG_WIDTH] : '0;
    assign out_valid = w_valid;
    assign full      = w_full;

`ifdef GON_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if ((|enable_in) && w_full && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gon_collector.sv
// ============================================================================
// Module : tb_gon_collector
// Brief  : Scoreboard bench for gon_collector: grants push expected words, a monitor pops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_gon_collector;
    import gon_pkg::*;

    localparam int ROWS = 12;
    localparam int COLS = 14;
    localparam int NPE  = ROWS * COLS;

    logic                              clk = 1'b0;
    logic                              reset;
    logic [ROWS-1:0][COLS-1:0][63:0]   data_in;
    logic [COLS-1:0][ROWS-1:0]         enable_in;
    logic [COLS-1:0][ROWS-1:0]         ready_out;
    logic [63:0]                       out_data;
    logic [3:0]                        out_row;
    logic [3:0]                        out_col;
    logic                              out_valid;
    logic                              out_ready;
    logic                              full;
    logic [31:0]                       stall_cnt;

    int         checks = 0;
    int         errors = 0;
    gon_entry_t exp_q[$];
    int         grant_log[$];
    bit         hold_en = 1'b0;
    int         last_gnt = -1;
    int         guard;

    always #5 clk = ~clk;

    gon_collector dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .enable_in (enable_in),
        .ready_out (ready_out),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [63:0] pe_data(input int idx);
        return {32'hC0DE_5EED, 32'(idx)};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Record any grant seen this cycle and queue the word it must produce.
    task automatic sample();
        @(negedge clk);
        last_gnt = -1;
        if (ready_out != '0) begin
            chk("grant_onehot", 96'($countones(ready_out)), 96'd1);
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (ready_out[c][r]) begin
                        chk("grant_to_requester", 96'(enable_in[c][r]), 96'd1);
                        last_gnt = r * COLS + c;
                        grant_log.push_back(r * COLS + c);
                        exp_q.push_back(gon_entry_t'{col_tag: 4'(c), row_tag: 4'(r),
                                                     data: data_in[r][c]});
                    end
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (last_gnt >= 0 && !hold_en) enable_in[last_gnt % COLS][last_gnt / COLS] = 1'b0;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic set_req(input int idx);
        enable_in[idx % COLS][idx / COLS] = 1'b1;
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        enable_in = '0;
        reset     = 1'b1;
        exp_q.delete();
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {out_col, out_row, out_data}, 96'd0);
            end else begin
                chk("out_word", {out_col, out_row, out_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        enable_in = '0;
        for (int i = 0; i < NPE; i++) data_in[i / COLS][i % COLS] = pe_data(i);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset.
        sample();
        chk("rst_ready_out", 96'(ready_out), 96'd0);
        chk("rst_out_valid", 96'(out_valid), 96'd0);
        chk("rst_full",      96'(full),      96'd0);
        chk("rst_stall_cnt", 96'(stall_cnt), 96'd0);
        chk("rst_out_data",  96'(out_data),  96'd0);
        advance();

        // Single word from PE(0,0).
        data_in[0][0]   = 64'hA5;
        enable_in[0][0] = 1'b1;
        out_ready       = 1'b1;
        step();
        chk("single_grant_idx", 96'(last_gnt), 96'd0);
        sample();
        chk("single_valid", 96'(out_valid), 96'd1);
        chk("single_data",  96'(out_data),  96'hA5);
        chk("single_tags",  96'({out_col, out_row}), 96'd0);
        advance();
        sample();
        chk("single_drained", 96'(out_valid), 96'd0);
        advance();
        data_in[0][0] = pe_data(0);

        // Every PE requesting: strict idx order with wrap.
        do_reset();
        hold_en   = 1'b1;
        enable_in = '1;
        out_ready = 1'b1;
        repeat (NPE + 2) step();
        hold_en   = 1'b0;
        enable_in = '0;
        repeat (3) step();
        chk("rr_all_count", 96'(grant_log.size()), 96'(NPE + 2));
        for (int i = 0; i < grant_log.size(); i++) begin
            chk("rr_all_order", 96'(grant_log[i]), 96'(i % NPE));
        end

        // Pointer at 167: 167 beats 5, then wrap to 5.
        do_reset();
        set_req(166);
        out_ready = 1'b1;
        step();
        set_req(5);
        set_req(167);
        repeat (4) step();
        chk("wrap_count", 96'(grant_log.size()), 96'd3);
        if (grant_log.size() == 3) begin
            chk("wrap_first",  96'(grant_log[1]), 96'd167);
            chk("wrap_second", 96'(grant_log[2]), 96'd5);
        end

        // Fill to full, stall, then a pop reopens the grant one cycle later.
        do_reset();
        for (int i = 0; i < 70; i++) set_req(i);
        repeat (64) step();
        repeat (10) step();
        out_ready = 1'b1;
        sample();
        chk("full_flag",      96'(full),             96'd1);
        chk("full_no_grant",  96'(ready_out),        96'd0);
        chk("full_pushes",    96'(grant_log.size()), 96'd64);
`ifdef GON_PERF_CNT_EN
        chk("stall_cnt",      96'(stall_cnt),        96'd10);
`else
        chk("stall_cnt",      96'(stall_cnt),        96'd0);
`endif
        advance();
        out_ready = 1'b0;
        sample();
        chk("pop_reopens_grant", 96'(last_gnt), 96'd64);
        advance();
        out_ready = 1'b1;
        guard = 0;
        while ((grant_log.size() < 70 || exp_q.size() != 0) && guard < 200) begin
            step();
            guard++;
        end
        chk("full_drain_done",  96'(guard < 200),      96'd1);
        chk("full_total_words", 96'(grant_log.size()), 96'd70);

        // Simultaneous push and pop at count 3.
        do_reset();
        set_req(10);
        set_req(11);
        set_req(12);
        repeat (3) step();
        set_req(13);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        sample();
        chk("pp_valid", 96'(out_valid), 96'd1);
        chk("pp_full",  96'(full),      96'd0);
        advance();
        out_ready = 1'b1;
        repeat (3) step();
        sample();
        chk("pp_count3_drained", 96'(out_valid),    96'd0);
        chk("pp_all_popped",     96'(exp_q.size()), 96'd0);
        advance();

        // Reset mid-burst drops buffered words; a pending request sees no grant.
        out_ready = 1'b0;
        set_req(20);
        set_req(21);
        set_req(22);
        repeat (2) step();
        reset = 1'b1;
        exp_q.delete();
        advance();
        sample();
        chk("midrst_valid",     96'(out_valid), 96'd0);
        chk("midrst_full",      96'(full),      96'd0);
        chk("midrst_ready_out", 96'(ready_out), 96'd0);
        advance();
        reset     = 1'b0;
        enable_in = '0;
        sample();
        chk("postrst_valid", 96'(out_valid), 96'd0);
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
